// File: rtl/button_debouncer_multi.sv
// N-channel push-button debouncer: sync, per-channel persistence counter, press/release pulses.
// Optional long-press pulse per channel is built only when LONG_PRESS_EN is defined.

module button_debouncer_lane #(
   parameter int CNT_W      = 16,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic press,
   output logic rel,
   output logic long_p
);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic             sync0, sync1;
   logic [CNT_W-1:0] cnt;
   logic             busy, flip;

   assign busy = (sync1 != stable);
   // Counter saturation is the acceptance point; the increment wraps cnt to 0 on the same edge.
   assign flip = busy && (&cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync0  <= 1'b0;
         sync1  <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
      end else begin
         sync0  <= raw ^ POL;
         sync1  <= sync0;
         cnt    <= busy ? cnt + CNT_W'(1) : '0;
         if (flip) stable <= ~stable;
         press  <= flip & ~stable;
         rel    <= flip & stable;
      end
   end

`ifdef LONG_PRESS_EN
   localparam logic [LONG_CNT_W-1:0] LC_PRE = {{(LONG_CNT_W-1){1'b1}}, 1'b0};

   logic [LONG_CNT_W-1:0] lc;

   // Pulse only on the step into saturation, so a long hold gives a single pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lc     <= '0;
         long_p <= 1'b0;
      end else begin
         if (!stable)     lc <= '0;
         else if (~&lc)   lc <= lc + LONG_CNT_W'(1);
         long_p <= stable && (lc == LC_PRE);
      end
   end
`else
   assign long_p = 1'b0 & (LONG_CNT_W > 0);
`endif

endmodule

module button_debouncer_multi #(
   parameter int N_BTN      = 4,
   parameter int CNT_W      = 16,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_stable,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);

   button_debouncer_lane #(
      .CNT_W      (CNT_W),
      .ACTIVE_LOW (ACTIVE_LOW),
      .LONG_CNT_W (LONG_CNT_W)
   ) u_lane [N_BTN-1:0] (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (btn_raw),
      .stable (btn_stable),
      .press  (btn_press),
      .rel    (btn_release),
      .long_p (btn_long)
   );

endmodule
